// File: rtl/sha512_pkg.sv
// sha512_pkg: shared constants and state type for the SHA-512 message padder.
package sha512_pkg;
    localparam int WordsPerBlock = 16;
    localparam int LenWidth = 128;
    localparam logic [7:0] PadByte = 8'h80;
    localparam logic [63:0] PadWord = {PadByte, 56'h0};
    localparam logic [3:0] LenHiIdx = 4'd14;
    localparam logic [3:0] LenLoIdx = 4'd15;
    typedef enum logic [1:0] {FILL, EMIT, EMIT_LAST} pad_state_e;
endpackage

// File: rtl/sha512_pad_word.sv
// sha512_pad_word: keeps bytes below k, puts the 0x80 marker at byte k, zeroes the rest.
module sha512_pad_word
    import sha512_pkg::*;
(
    input  logic [63:0] data,
    input  logic [3:0]  bytes,
    output logic [63:0] word
);
    for (genvar b = 0; b < 8; b++) begin : g_byte
        assign word[63-8*b -: 8] = (4'(b) < bytes) ? data[63-8*b -: 8] :
                                   (4'(b) == bytes) ? PadByte : 8'h00;
    end
endmodule

// File: rtl/sha512_padder.sv
// sha512_padder: packs 64-bit message words into FIPS 180-4 padded 1024-bit blocks.
// Optional SHA512_PADDER_ERR_CHECK_EN adds a sticky err_o for bad byte counts and length wrap.
module sha512_padder
    import sha512_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int BlockWidth = 1024,
    parameter int LenWidth = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DataWidth-1:0]  in_data_i,
    input  logic [3:0]            in_bytes_i,
    input  logic                  in_last_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic                  last_block_o,
    output logic                  err_o
);
    pad_state_e state, state_d;
    logic [0:WordsPerBlock-1][63:0] blk;
    logic [LenWidth-1:0] len, len_next;
    logic [3:0] idx, k;
    logic [4:0] pad_idx;
    logic [63:0] padded;
    logic extra, pad_next, acc, hs, late;

    assign acc = in_valid_i && in_ready_o;
    assign hs = block_valid_o && block_ready_i;
    assign k = !in_last_i ? 4'd8 : (in_bytes_i > 4'd8) ? 4'd8 : in_bytes_i;
    assign len_next = len + {{(LenWidth-7){1'b0}}, k, 3'b000};
    // a full last word pushes the marker into the following slot
    assign pad_idx = {1'b0, idx} + {4'd0, k == 4'd8};
    assign late = pad_idx >= 5'd14;
    assign block_o = blk;

    sha512_pad_word u_pad (.data(in_data_i), .bytes(k), .word(padded));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= FILL;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        in_ready_o = 1'b0;
        block_valid_o = 1'b0;
        last_block_o = 1'b0;
        case (state)
            FILL: begin
                in_ready_o = !rst_i;
                state_d = !acc ? FILL : in_last_i ? (late ? EMIT : EMIT_LAST)
                                                  : (idx == 4'd15 ? EMIT : FILL);
            end
            EMIT: begin
                block_valid_o = 1'b1;
                state_d = !block_ready_i ? EMIT : extra ? EMIT_LAST : FILL;
            end
            EMIT_LAST: begin
                block_valid_o = 1'b1;
                last_block_o = 1'b1;
                state_d = block_ready_i ? FILL : EMIT_LAST;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blk <= '0;
            len <= '0;
            idx <= '0;
            extra <= 1'b0;
            pad_next <= 1'b0;
        end else if (acc) begin
            len <= len_next;
            idx <= idx + 4'd1;
            blk[idx] <= padded;
            if (in_last_i && k == 4'd8 && idx != 4'd15) blk[idx+4'd1] <= PadWord;
            if (in_last_i && !late) begin
                blk[LenHiIdx] <= len_next[127:64];
                blk[LenLoIdx] <= len_next[63:0];
            end
            if (in_last_i && late) begin
                extra <= 1'b1;
                pad_next <= idx == 4'd15 && k == 4'd8;
            end
        end else if (hs && state == EMIT && extra) begin
            blk <= '0;
            blk[0] <= pad_next ? PadWord : 64'h0;
            blk[LenHiIdx] <= len[127:64];
            blk[LenLoIdx] <= len[63:0];
            extra <= 1'b0;
            pad_next <= 1'b0;
        end else if (hs) begin
            blk <= '0;
            idx <= '0;
            if (state == EMIT_LAST) len <= '0;
        end
    end

`ifdef SHA512_PADDER_ERR_CHECK_EN
    logic err;
    always_ff @(posedge clk_i) begin
        if (rst_i) err <= 1'b0;
        else if (acc && ((in_last_i && in_bytes_i > 4'd8) || len_next < len)) err <= 1'b1;
    end
    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif
endmodule
